// File: rtl/button_event_encoder.sv
`default_nettype none
// ============================================================================
// Module      : button_event_encoder
// Description : Front end for the player push-button. Synchronises the raw,
//               active-low, bouncy button, debounces it on a slow sample
//               tick, and turns the clean level into PRESS / LONG / REPEAT /
//               RELEASE events held in a 2-entry FIFO behind valid/ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   i_button     in   raw push-button, active-low (0 = pressed), async to clk
//   i_evt_ready  in   consumer accepts the head event this cycle
//   o_evt_valid  out  FIFO non-empty
//   o_evt_code   out  head event: 00 RELEASE, 01 PRESS, 10 LONG, 11 REPEAT
//   o_pressed    out  debounced level, 1 = held
//   o_dropped    out  sticky: an event was lost because the FIFO was full
// ============================================================================
module button_event_encoder #(
  parameter int TICK_DIV       = 250000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int LONG_TICKS     = 50,
  parameter int REPEAT_TICKS   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_button,
  input  logic       i_evt_ready,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_code,
  output logic       o_pressed,
  output logic       o_dropped
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_TICK_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int c_DEB_W    = $clog2(DEBOUNCE_TICKS + 1);
  localparam int c_HOLD_MAX = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int c_HOLD_W   = (c_HOLD_MAX < 1) ? 1 : $clog2(c_HOLD_MAX + 1);

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
  localparam logic [c_DEB_W-1:0]  c_DEB_THR   = c_DEB_W'(DEBOUNCE_TICKS);
  localparam logic [c_HOLD_W-1:0] c_LONG      = c_HOLD_W'(LONG_TICKS);
  localparam logic [c_HOLD_W-1:0] c_REPEAT    = c_HOLD_W'(REPEAT_TICKS);

  localparam logic [1:0] c_EVT_RELEASE = 2'b00;
  localparam logic [1:0] c_EVT_PRESS   = 2'b01;
  localparam logic [1:0] c_EVT_LONG    = 2'b10;
  localparam logic [1:0] c_EVT_REPEAT  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HELD   = 2'd1,
    S_REPEAT = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic                r_sync1;
  logic                r_sync2;
  logic                w_btn_s;

  logic [c_TICK_W-1:0] r_tick_cnt;
  logic                w_tick;

  logic [c_DEB_W-1:0]  r_deb_cnt;
  logic [c_DEB_W-1:0]  w_deb_next;
  logic                r_pressed;
  logic                r_pressed_d;
  logic                w_rise;
  logic                w_fall;

  state_t              r_state;
  logic [c_HOLD_W-1:0] r_hold;
  logic                w_push;
  logic [1:0]          w_push_code;

  logic [1:0]          r_head;
  logic [1:0]          r_tail;
  logic [1:0]          r_count;
  logic                r_dropped;
  logic                w_pop;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. Flops rest at 1 so reset looks like "released".
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
    end
  end

  // Button is active-low; flip it so 1 means pressed from here on.
  assign w_btn_s = ~r_sync2;

  // --------------------------------------------------------------------------
  // Sample tick: one-cycle strobe every TICK_DIV clocks.
  // --------------------------------------------------------------------------
  assign w_tick = (r_tick_cnt == c_TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: the level only flips after DEBOUNCE_TICKS consecutive ticks
  // disagreeing with it; any agreeing sample restarts the run.
  // --------------------------------------------------------------------------
  assign w_deb_next = r_deb_cnt + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb_cnt   <= '0;
      r_pressed   <= 1'b0;
      r_pressed_d <= 1'b0;
    end else begin
      r_pressed_d <= r_pressed;
      if (w_tick) begin
        if (w_btn_s == r_pressed) begin
          r_deb_cnt <= '0;
        end else if (w_deb_next == c_DEB_THR) begin
          r_pressed <= ~r_pressed;
          r_deb_cnt <= '0;
        end else begin
          r_deb_cnt <= w_deb_next;
        end
      end
    end
  end

  // Level edges are seen the cycle after the deciding tick, which is exactly
  // when the event push has to happen.
  assign w_rise = r_pressed & ~r_pressed_d;
  assign w_fall = ~r_pressed & r_pressed_d;

  // --------------------------------------------------------------------------
  // Event decode. Hold-count matches are only ever observed in the cycle
  // after a tick, so they line up with level edges; a release found in the
  // same cycle wins over LONG/REPEAT.
  // --------------------------------------------------------------------------
  always_comb begin
    w_push      = 1'b0;
    w_push_code = c_EVT_RELEASE;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_push      = 1'b1;
          w_push_code = c_EVT_PRESS;
        end
      end
      S_HELD: begin
        if (w_fall) begin
          w_push      = 1'b1;
          w_push_code = c_EVT_RELEASE;
        end else if (r_hold == c_LONG) begin
          w_push      = 1'b1;
          w_push_code = c_EVT_LONG;
        end
      end
      S_REPEAT: begin
        if (w_fall) begin
          w_push      = 1'b1;
          w_push_code = c_EVT_RELEASE;
        end else if (r_hold == c_REPEAT) begin
          w_push      = 1'b1;
          w_push_code = c_EVT_REPEAT;
        end
      end
      default: begin
        w_push      = 1'b0;
        w_push_code = c_EVT_RELEASE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Press state machine and hold counter. The counter is cleared as soon as
  // it hits its threshold, so it never exceeds the larger of the two limits.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_hold  <= '0;
            r_state <= S_HELD;
          end
        end
        S_HELD: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end else if (r_hold == c_LONG) begin
            r_hold  <= '0;
            r_state <= S_REPEAT;
          end else if (w_tick) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        S_REPEAT: begin
          if (w_fall) begin
            r_state <= S_IDLE;
          end else if (r_hold == c_REPEAT) begin
            r_hold <= '0;
          end else if (w_tick) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_hold  <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Two-entry FIFO kept as head/tail registers plus an occupancy count.
  // A push into a full FIFO survives only if the head pops in the same cycle.
  // --------------------------------------------------------------------------
  assign w_pop = (r_count != 2'd0) && i_evt_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head    <= c_EVT_RELEASE;
      r_tail    <= c_EVT_RELEASE;
      r_count   <= 2'd0;
      r_dropped <= 1'b0;
    end else begin
      case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head  <= w_push_code;
            r_count <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_push_code;
          end else if (w_push) begin
            r_tail  <= w_push_code;
            r_count <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) begin
              r_tail <= w_push_code;
            end else begin
              r_count <= 2'd1;
            end
          end else if (w_push) begin
            r_dropped <= 1'b1;
          end
        end
        default: begin
          r_count <= 2'd0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_evt_valid = (r_count != 2'd0);
  assign o_evt_code  = r_head;
  assign o_pressed   = r_pressed;
  assign o_dropped   = r_dropped;

endmodule
`default_nettype wire
